// File: rtl/s8_4bits_ctrl.sv
// s8_4bits_ctrl: sequencer for the nibble-serial 8-bit S-box datapath.
// Accepts bytes on a valid/ready handshake in phase O, feeds the datapath the
// high then the low nibble, and drives the mc_a/mc_b phase controls. It also
// reassembles the substituted nibbles and queues the result bytes in a
// first-word-fall-through FIFO. A credit counter bounds FIFO entries plus
// in-flight bytes.
// Ports:
//   clk, reset          clock and async active-high reset
//   enable              gates acceptance of new bytes only
//   in_valid/in_ready   input byte handshake, in_data byte
//   out_valid/out_ready output byte handshake, out_data FIFO head
//   dp_s_in, dp_mc_a, dp_mc_b   drive the datapath
//   dp_s_out            nibble returned by the datapath
//   busy                any byte in flight or queued
module s8_4bits_ctrl #(
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [3:0] dp_s_in,
  output logic       dp_mc_a,
  output logic       dp_mc_b,
  input  logic [3:0] dp_s_out,
  output logic       busy
);

  localparam int unsigned OW = $clog2(OUT_DEPTH + 1);
  localparam int unsigned PW = $clog2(OUT_DEPTH);
  localparam logic [OW-1:0] OCC_MAX  = OW'(OUT_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(OUT_DEPTH - 1);

  logic          r_ph;      // 1 = phase O, 0 = phase E
  logic          r_mc_a;
  logic [OW-1:0] r_occ;
  logic [7:0]    r_hold;
  logic [3:0]    r_vld;     // accept pulse delayed by 1..4 cycles
  logic [3:0]    r_s_in;
  logic [3:0]    r_res_hi;
  logic [7:0]    r_mem [OUT_DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [OW-1:0] r_cnt;

  logic          w_acc;
  logic          w_pop;
  logic          w_wr;
  logic [3:0]    w_s_in_nxt;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Handshake qualifiers; in_ready depends only on registered state and enable.
  assign in_ready  = ~reset & enable & r_ph & (r_occ < OCC_MAX);
  assign w_acc     = in_valid & in_ready;
  assign out_valid = (r_cnt != '0);
  assign w_pop     = out_valid & out_ready;
  assign w_wr      = r_vld[3];
  assign out_data  = r_mem[r_rp];
  assign busy      = (r_occ != '0);
  assign dp_s_in   = r_s_in;
  assign dp_mc_a   = r_mc_a;
  assign dp_mc_b   = r_ph;

  // Next feed nibble: high nibble straight from the accepted byte, low nibble
  // from the hold register one cycle later. The two cases never coincide since
  // acceptance only happens in O and r_vld[0] is only set in E.
  always_comb begin
    w_s_in_nxt = 4'h0;
    if (w_acc) begin
      w_s_in_nxt = in_data[7:4];
    end else if (r_vld[0]) begin
      w_s_in_nxt = r_hold[3:0];
    end
  end

  // Phase, feed, capture and credit tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ph     <= 1'b1;
      r_mc_a   <= 1'b0;
      r_hold   <= '0;
      r_vld    <= '0;
      r_s_in   <= '0;
      r_res_hi <= '0;
      r_occ    <= '0;
    end else begin
      r_ph   <= ~r_ph;
      r_mc_a <= r_ph;
      if (w_acc) begin
        r_hold <= in_data;
      end
      r_vld  <= {r_vld[2:0], w_acc};
      r_s_in <= w_s_in_nxt;
      if (r_vld[2]) begin
        r_res_hi <= dp_s_out;
      end
      case ({w_acc, w_pop})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Output FIFO; credits guarantee it never overflows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(OUT_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp] <= {r_res_hi, dp_s_out};
        r_wp        <= f_inc(r_wp);
      end
      if (w_pop) begin
        r_rp <= f_inc(r_rp);
      end
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + OW'(1);
        2'b01:   r_cnt <= r_cnt - OW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_s8_4bits_ctrl.sv
// Bench for s8_4bits_ctrl: a behavioural datapath stand-in plus a
// transaction-level reference (queue of accepted bytes with due cycles).
module tb_s8_4bits_ctrl;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] dp_s_in;
  logic       dp_mc_a;
  logic       dp_mc_b;
  logic [3:0] dp_s_out;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  s8_4bits_ctrl #(.OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .dp_s_in(dp_s_in), .dp_mc_a(dp_mc_a), .dp_mc_b(dp_mc_b),
    .dp_s_out(dp_s_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in byte permutation; the controller is transparent to the mapping.
  function automatic logic [7:0] s8(input logic [7:0] x);
    logic [7:0] t;
    t = 8'(x * 8'd29 + 8'd113);
    return t ^ 8'h5A;
  endfunction

  // Datapath stand-in: output nibble two cycles behind its input nibbles.
  logic [3:0] h1, h2, h3;
  logic [7:0] dp_w;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      h1 <= '0; h2 <= '0; h3 <= '0;
    end else begin
      h1 <= dp_s_in; h2 <= h1; h3 <= h2;
    end
  end
  always_comb begin
    dp_w = 8'h00;
    if (!dp_mc_b) begin
      dp_w     = s8({h2, h1});
      dp_s_out = dp_w[7:4];
    end else begin
      dp_w     = s8({h3, h2});
      dp_s_out = dp_w[3:0];
    end
  end

  typedef struct {
    logic [7:0] raw;
    logic [7:0] d;
    int         rdy;
  } ent_t;
  ent_t q[$];

  typedef struct {
    logic       en;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       x_ir;
    logic       x_ov;
    logic [7:0] x_od;
    logic       x_busy;
  } vec_t;
  vec_t tbl[20];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cyc=%0d actual=0x%0h required=0x%0h", nm, idx, cyc, act, exp);
    end
  endtask

  // Reference: every accepted byte is due at the output 5 cycles later,
  // feeds its high/low nibble 1/2 cycles after acceptance, and holds a credit
  // until popped.
  task automatic monitor();
    logic       exp_o, exp_ir, exp_ov;
    logic [3:0] exp_si;
    if (reset) begin
      chk("rst_in_ready", 0, 32'(in_ready), 32'(0));
      chk("rst_out_valid", 0, 32'(out_valid), 32'(0));
      chk("rst_out_data", 0, 32'(out_data), 32'(0));
      chk("rst_busy", 0, 32'(busy), 32'(0));
      chk("rst_s_in", 0, 32'(dp_s_in), 32'(0));
      chk("rst_mc_a", 0, 32'(dp_mc_a), 32'(0));
      chk("rst_mc_b", 0, 32'(dp_mc_b), 32'(1));
      q.delete();
      return;
    end
    exp_o  = (cyc % 2 == 0);
    exp_ir = enable && exp_o && (q.size() < DEPTH);
    exp_ov = (q.size() > 0) && (q[0].rdy <= cyc);
    exp_si = 4'h0;
    foreach (q[i]) begin
      if (q[i].rdy == cyc + 4) exp_si = q[i].raw[7:4];
      else if (q[i].rdy == cyc + 3) exp_si = q[i].raw[3:0];
    end
    chk("mc_a", 0, 32'(dp_mc_a), 32'(!exp_o));
    chk("mc_b", 0, 32'(dp_mc_b), 32'(exp_o));
    chk("in_ready", 0, 32'(in_ready), 32'(exp_ir));
    chk("out_valid", 0, 32'(out_valid), 32'(exp_ov));
    if (exp_ov) chk("out_data", 0, 32'(out_data), 32'(q[0].d));
    chk("s_in", 0, 32'(dp_s_in), 32'(exp_si));
    chk("busy", 0, 32'(busy), 32'(q.size() != 0));
    if (in_valid && exp_ir) q.push_back('{raw: in_data, d: s8(in_data), rdy: cyc + 5});
    if (exp_ov && out_ready) void'(q.pop_front());
  endtask

  task automatic sample();
    @(negedge clk);
    monitor();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      adv();
    end
  endtask

  task automatic push(input logic [7:0] d, output int acc);
    in_valid = 1'b1;
    in_data  = d;
    acc      = -1;
    for (int c = 0; c < 40; c++) begin
      sample();
      if (in_ready) acc = cyc;
      adv();
      if (acc >= 0) break;
    end
    in_valid = 1'b0;
    chk("push_accept", 0, 32'(acc >= 0), 32'(1));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int c = 0; c < 200 && q.size() != 0; c++) begin
      sample();
      adv();
    end
    sample();
    chk("drain_busy", 0, 32'(busy), 32'(0));
    adv();
  endtask

  function automatic vec_t mk(input logic en, input logic iv, input logic [7:0] d, input logic ordy,
                              input logic ir, input logic ov, input logic [7:0] od, input logic b);
    vec_t v;
    v.en = en; v.iv = iv; v.d = d; v.ordy = ordy;
    v.x_ir = ir; v.x_ov = ov; v.x_od = od; v.x_busy = b;
    return v;
  endfunction

  initial begin
    int k, first, last, acc, lat;
    // Single byte, phase rule, held output, enable gating; cycle 0 is the first O.
    tbl[0]  = mk(1, 1, 8'h00, 1, 1, 0, 8'h00, 0);
    tbl[1]  = mk(1, 0, 8'h00, 1, 0, 0, 8'h00, 1);
    tbl[2]  = mk(1, 0, 8'h00, 1, 1, 0, 8'h00, 1);
    tbl[3]  = mk(1, 0, 8'h00, 1, 0, 0, 8'h00, 1);
    tbl[4]  = mk(1, 0, 8'h00, 1, 1, 0, 8'h00, 1);
    tbl[5]  = mk(1, 0, 8'h00, 1, 0, 1, s8(8'h00), 1);
    tbl[6]  = mk(1, 0, 8'h00, 1, 1, 0, 8'h00, 0);
    tbl[7]  = mk(1, 1, 8'h3C, 1, 0, 0, 8'h00, 0);
    tbl[8]  = mk(1, 1, 8'h3C, 1, 1, 0, 8'h00, 0);
    tbl[9]  = mk(1, 0, 8'h00, 1, 0, 0, 8'h00, 1);
    tbl[10] = mk(1, 0, 8'h00, 1, 1, 0, 8'h00, 1);
    tbl[11] = mk(1, 0, 8'h00, 1, 0, 0, 8'h00, 1);
    tbl[12] = mk(1, 0, 8'h00, 1, 1, 0, 8'h00, 1);
    tbl[13] = mk(1, 0, 8'h00, 0, 0, 1, s8(8'h3C), 1);
    tbl[14] = mk(1, 0, 8'h00, 0, 1, 1, s8(8'h3C), 1);
    tbl[15] = mk(1, 0, 8'h00, 1, 0, 1, s8(8'h3C), 1);
    tbl[16] = mk(1, 0, 8'h00, 1, 1, 0, 8'h00, 0);
    tbl[17] = mk(0, 1, 8'h55, 1, 0, 0, 8'h00, 0);
    tbl[18] = mk(0, 1, 8'h55, 1, 0, 0, 8'h00, 0);
    tbl[19] = mk(1, 0, 8'h00, 1, 0, 0, 8'h00, 0);

    reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    idle(3);
    reset = 1'b0;
    cyc   = 0;

    foreach (tbl[i]) begin
      enable = tbl[i].en; in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].ordy;
      sample();
      chk("tbl_in_ready", i, 32'(in_ready), 32'(tbl[i].x_ir));
      chk("tbl_out_valid", i, 32'(out_valid), 32'(tbl[i].x_ov));
      if (tbl[i].x_ov) chk("tbl_out_data", i, 32'(out_data), 32'(tbl[i].x_od));
      chk("tbl_busy", i, 32'(busy), 32'(tbl[i].x_busy));
      adv();
    end
    enable = 1'b1; in_valid = 1'b0;
    drain();

    // Streaming 0x00..0xFF at full rate.
    out_ready = 1'b1; k = 0; first = -1; last = -1; in_data = 8'h00; in_valid = 1'b1;
    for (int c = 0; c < 1200 && k < 256; c++) begin
      sample();
      if (in_valid && in_ready) begin
        if (k == 0) first = cyc;
        last = cyc;
        k++;
      end
      adv();
      in_data = 8'(k);
      if (k == 256) in_valid = 1'b0;
    end
    chk("stream_count", 0, 32'(k), 32'(256));
    chk("stream_span", 0, 32'(last - first), 32'(510));
    drain();

    // Backpressure: only DEPTH credits available.
    out_ready = 1'b0; k = 0; in_valid = 1'b1; in_data = 8'hA0;
    for (int c = 0; c < 14; c++) begin
      sample();
      if (in_valid && in_ready) k++;
      adv();
      in_data = 8'(160 + k);
    end
    chk("bp_accepted", 0, 32'(k), 32'(4));
    out_ready = 1'b1;
    for (int c = 0; c < 40 && k < 6; c++) begin
      sample();
      if (in_valid && in_ready) k++;
      adv();
      in_data = 8'(160 + k);
      if (k == 6) in_valid = 1'b0;
    end
    chk("bp_total", 0, 32'(k), 32'(6));
    drain();

    // Simultaneous push and pop keep the credit count.
    out_ready = 1'b0;
    push(8'h11, acc); push(8'h22, acc); push(8'h33, acc);
    idle(8);
    while (cyc % 2 != 0) idle(1);
    in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
    sample();
    chk("sim_in_ready", 0, 32'(in_ready), 32'(1));
    chk("sim_out_valid", 0, 32'(out_valid), 32'(1));
    adv();
    in_valid = 1'b0; out_ready = 1'b0;
    idle(1);
    sample();
    chk("sim_occ_kept", 0, 32'(in_ready), 32'(1));
    adv();
    push(8'h78, acc);
    idle(1);
    sample();
    chk("sim_full_block", 0, 32'(in_ready), 32'(0));
    adv();
    drain();

    // Reset with two bytes queued and two in flight.
    out_ready = 1'b0;
    push(8'hC1, acc); push(8'hC2, acc); push(8'hC3, acc); push(8'hC4, acc);
    reset = 1'b1;
    sample();
    chk("mid_rst_out_valid", 0, 32'(out_valid), 32'(0));
    chk("mid_rst_busy", 0, 32'(busy), 32'(0));
    chk("mid_rst_in_ready", 0, 32'(in_ready), 32'(0));
    adv();
    idle(1);
    reset = 1'b0;
    cyc   = 0;
    out_ready = 1'b1;
    idle(8);
    push(8'h99, acc);
    lat = -1;
    for (int c = 0; c < 20 && lat < 0; c++) begin
      sample();
      if (out_valid) begin
        lat = cyc - acc;
        chk("rst_after_data", 0, 32'(out_data), 32'(s8(8'h99)));
      end
      adv();
    end
    chk("rst_after_latency", 0, 32'(lat), 32'(5));
    drain();

    // Randomized traffic with varying backpressure and enable drops.
    for (int c = 0; c < 3000; c++) begin
      enable    = ($urandom_range(0, 9) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = (c < 1000) ? 1'b1 : (c < 2000) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 4) == 0);
      sample();
      adv();
    end
    enable = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

endmodule
